// File: rtl/alu_issue_if.sv
// Decode-to-EX bus for the ALU issue stage: decoded instruction, bypass buses, ALU drive.
interface alu_issue_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_rdata1;
  logic [XLEN-1:0] in_rdata2;
  logic [XLEN-1:0] in_imm;
  logic            in_use_imm;
  logic [3:0]      in_aluop;
  logic            in_memread;
  logic            in_regwrite;
  logic            flush;
  logic [4:0]      exmem_rd;
  logic            exmem_regwrite;
  logic [XLEN-1:0] exmem_result;
  logic [4:0]      memwb_rd;
  logic            memwb_regwrite;
  logic [XLEN-1:0] memwb_data;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic [3:0]      select;
  logic            ex_valid;
  logic [4:0]      ex_rd;
  logic            ex_regwrite;
  logic            ex_memread;
  logic            stall;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rdata1, in_rdata2, in_imm, in_use_imm,
    output in_aluop, in_memread, in_regwrite, flush,
    output exmem_rd, exmem_regwrite, exmem_result, memwb_rd, memwb_regwrite, memwb_data,
    input  data1, data2, select, ex_valid, ex_rd, ex_regwrite, ex_memread, stall
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rdata1, in_rdata2, in_imm, in_use_imm,
    input  in_aluop, in_memread, in_regwrite, flush,
    input  exmem_rd, exmem_regwrite, exmem_result, memwb_rd, memwb_regwrite, memwb_data,
    output data1, data2, select, ex_valid, ex_rd, ex_regwrite, ex_memread, stall
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX stage ahead of the ALU: operand forwarding, load-use bubbles and MUL/DIV hold.
module alu_issue_stage #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input logic        clk,
  input logic        resetn,
  alu_issue_if.slave bus
);

  localparam int unsigned   CntW    = $clog2(MULDIV_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(MULDIV_CYCLES - 1);

  typedef enum logic {StRun, StHold} state_e;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic [3:0]      aluop;
    logic            memread;
    logic            regwrite;
  } ex_t;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  ex_t             ex_q, ex_d;
  ex_t             in_slot;
  logic [XLEN-1:0] hold1_q, hold1_d;
  logic [XLEN-1:0] hold2_q, hold2_d;
  logic [XLEN-1:0] fwd1, fwd2, op2;
  logic            is_muldiv, load_use, stall;

  // Per-operand bypass: EX/MEM beats MEM/WB; x0 is never forwarded.
  always_comb begin
    fwd1 = ex_q.rdata1;
    fwd2 = ex_q.rdata2;
    if (ex_q.rs1 != 5'd0 && bus.exmem_regwrite && bus.exmem_rd == ex_q.rs1) begin
      fwd1 = bus.exmem_result;
    end else if (ex_q.rs1 != 5'd0 && bus.memwb_regwrite && bus.memwb_rd == ex_q.rs1) begin
      fwd1 = bus.memwb_data;
    end
    if (ex_q.rs2 != 5'd0 && bus.exmem_regwrite && bus.exmem_rd == ex_q.rs2) begin
      fwd2 = bus.exmem_result;
    end else if (ex_q.rs2 != 5'd0 && bus.memwb_regwrite && bus.memwb_rd == ex_q.rs2) begin
      fwd2 = bus.memwb_data;
    end
    op2 = ex_q.use_imm ? ex_q.imm : fwd2;
  end

  // Hazard detection and the slot that a normal capture would load.
  always_comb begin
    is_muldiv = ex_q.valid && (ex_q.aluop[3:1] == 3'b100);
    load_use  = ex_q.valid && ex_q.memread && (ex_q.rd != 5'd0) && bus.in_valid &&
                ((bus.in_rs1 == ex_q.rd) || (!bus.in_use_imm && bus.in_rs2 == ex_q.rd));
    in_slot          = '0;
    in_slot.valid    = bus.in_valid && !bus.flush;
    in_slot.rs1      = bus.in_rs1;
    in_slot.rs2      = bus.in_rs2;
    in_slot.rd       = bus.in_rd;
    in_slot.rdata1   = bus.in_rdata1;
    in_slot.rdata2   = bus.in_rdata2;
    in_slot.imm      = bus.in_imm;
    in_slot.use_imm  = bus.in_use_imm;
    in_slot.aluop    = bus.in_aluop;
    in_slot.memread  = bus.in_memread && in_slot.valid;
    in_slot.regwrite = bus.in_regwrite && in_slot.valid;
  end

  // FSM next state: RUN captures/bubbles, HOLD freezes EX for the MUL/DIV duration.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ex_d    = ex_q;
    hold1_d = hold1_q;
    hold2_d = hold2_q;
    stall   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (is_muldiv) begin
          // First occupancy cycle: freeze the forwarded operands, keep the op in EX.
          stall   = 1'b1;
          state_d = StHold;
          cnt_d   = CntW'(1);
          hold1_d = fwd1;
          hold2_d = op2;
        end else if (load_use) begin
          stall = 1'b1;
          ex_d  = '0;
        end else begin
          ex_d = in_slot;
        end
      end
      StHold: begin
        if (cnt_q == CntLast) begin
          state_d = StRun;
          cnt_d   = '0;
          ex_d    = in_slot;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = '0;
      end
    endcase
  end

  // State and EX pipeline registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StRun;
      cnt_q   <= '0;
      ex_q    <= '0;
      hold1_q <= '0;
      hold2_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
      hold1_q <= hold1_d;
      hold2_q <= hold2_d;
    end
  end

  assign bus.data1       = (state_q == StHold) ? hold1_q : fwd1;
  assign bus.data2       = (state_q == StHold) ? hold2_q : op2;
  assign bus.select      = ex_q.aluop;
  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_rd       = ex_q.rd;
  assign bus.ex_regwrite = ex_q.valid && ex_q.regwrite;
  assign bus.ex_memread  = ex_q.valid && ex_q.memread;
  assign bus.stall       = stall;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: driver queues expected outputs, monitor compares.
module tb_alu_issue_stage;

  logic clk;
  logic resetn;

  alu_issue_if #(.XLEN(32)) bus ();

  alu_issue_stage #(.XLEN(32), .MULDIV_CYCLES(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [3:0]  sel;
    logic        v;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        st;
  } exp_t;

  exp_t  sb_q[$];
  string nm_q[$];
  int    checks = 0;
  int    errors = 0;
  exp_t  zero_e;
  exp_t  div_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(logic [31:0] d1, logic [31:0] d2, logic [3:0] sel, logic v,
                              logic [4:0] rd, logic rw, logic mr, logic st);
    exp_t e;
    e.d1 = d1; e.d2 = d2; e.sel = sel; e.v = v; e.rd = rd; e.rw = rw; e.mr = mr; e.st = st;
    return e;
  endfunction

  task automatic idle();
    bus.in_valid = 0; bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_rd = 0;
    bus.in_rdata1 = 0; bus.in_rdata2 = 0; bus.in_imm = 0; bus.in_use_imm = 0;
    bus.in_aluop = 0; bus.in_memread = 0; bus.in_regwrite = 0; bus.flush = 0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                       input logic use_imm, input logic [3:0] op, input logic mr,
                       input logic rw);
    bus.in_valid = 1; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd;
    bus.in_rdata1 = rd1; bus.in_rdata2 = rd2; bus.in_imm = imm; bus.in_use_imm = use_imm;
    bus.in_aluop = op; bus.in_memread = mr; bus.in_regwrite = rw;
  endtask

  task automatic set_fwd(input logic [4:0] exrd, input logic exrw, input logic [31:0] exres,
                         input logic [4:0] mwrd, input logic mwrw, input logic [31:0] mwdat);
    bus.exmem_rd = exrd; bus.exmem_regwrite = exrw; bus.exmem_result = exres;
    bus.memwb_rd = mwrd; bus.memwb_regwrite = mwrw; bus.memwb_data = mwdat;
  endtask

  // Queue the expectation for the current cycle, then advance to just after the next edge.
  task automatic cyc(input string nm, input exp_t e);
    sb_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Monitor: mid-cycle, compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t  e;
      exp_t  g;
      string nm;
      e = sb_q.pop_front();
      nm = nm_q.pop_front();
      g = mk(bus.data1, bus.data2, bus.select, bus.ex_valid, bus.ex_rd, bus.ex_regwrite,
             bus.ex_memread, bus.stall);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s: got d1=%h d2=%h sel=%h v=%b rd=%0d rw=%b mr=%b st=%b; want d1=%h d2=%h sel=%h v=%b rd=%0d rw=%b mr=%b st=%b",
                 nm, g.d1, g.d2, g.sel, g.v, g.rd, g.rw, g.mr, g.st,
                 e.d1, e.d2, e.sel, e.v, e.rd, e.rw, e.mr, e.st);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    zero_e = mk(0, 0, 0, 0, 0, 0, 0, 0);
    div_e  = mk(32'h50, 32'd7, 4'h9, 1, 8, 1, 0, 1);
    resetn = 0;
    idle();
    set_fwd(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    cyc("reset", zero_e);
    resetn = 1;
    // ADD x3,x1,x2 enters an empty EX
    issue(1, 2, 3, 32'h111, 32'h222, 0, 0, 4'h0, 0, 1);
    cyc("empty_ex", zero_e);
    // EX/MEM and MEM/WB both target x1: EX/MEM wins
    issue(3, 2, 4, 32'h5, 32'h6, 0, 0, 4'h1, 0, 1);
    set_fwd(1, 1, 32'h10, 1, 1, 32'h20);
    cyc("fwd_exmem_wins", mk(32'h10, 32'h222, 4'h0, 1, 3, 1, 0, 0));
    // EX/MEM match without regwrite is ignored; MEM/WB feeds rs2
    issue(0, 0, 7, 32'h1234, 32'h99, 32'hFFFF_FFF0, 1, 4'h0, 0, 1);
    set_fwd(3, 0, 32'hAA, 2, 1, 32'h77);
    cyc("fwd_memwb", mk(32'h5, 32'h77, 4'h1, 1, 4, 1, 0, 0));
    // x0 targets on both bypass buses must not forward; immediate drives operand 2
    issue(1, 0, 5, 32'h100, 0, 32'h4, 1, 4'h0, 1, 1);
    set_fwd(0, 1, 32'hFFFF, 0, 1, 32'h5555);
    cyc("x0_no_fwd", mk(32'h1234, 32'hFFFF_FFF0, 4'h0, 1, 7, 1, 0, 0));
    // LW x5 in EX, ADD x6,x5,x0 decoded: load-use stall
    issue(5, 0, 6, 32'h33, 0, 0, 0, 4'h0, 0, 1);
    set_fwd(0, 0, 0, 0, 0, 0);
    cyc("loaduse_stall", mk(32'h100, 32'h4, 4'h0, 1, 5, 1, 1, 1));
    cyc("bubble", zero_e);
    // ADD now in EX, load data arrives on MEM/WB; DIV decoded
    issue(1, 2, 8, 32'd100, 32'd7, 0, 0, 4'h9, 0, 1);
    set_fwd(0, 0, 0, 5, 1, 32'hDEAD);
    cyc("loaduse_fwd", mk(32'hDEAD, 0, 4'h0, 1, 6, 1, 0, 0));
    // DIV occupies EX 4 cycles; operands frozen at 0x50/7 though bypass changes
    issue(10, 11, 9, 32'hA, 32'hB, 0, 0, 4'h3, 0, 1);
    set_fwd(1, 1, 32'h50, 0, 0, 0);
    cyc("div_c1", div_e);
    set_fwd(1, 1, 32'h60, 2, 1, 32'h70);
    bus.flush = 1;
    cyc("div_c2", div_e);
    bus.flush = 0;
    set_fwd(1, 1, 32'h61, 2, 1, 32'h71);
    cyc("div_c3", div_e);
    cyc("div_c4", mk(32'h50, 32'd7, 4'h9, 1, 8, 1, 0, 0));
    // OR enters on cycle 5; next instruction is flushed
    issue(13, 14, 12, 32'h1, 32'h2, 0, 0, 4'h4, 0, 1);
    bus.flush = 1;
    set_fwd(0, 0, 0, 0, 0, 0);
    cyc("after_div", mk(32'hA, 32'hB, 4'h3, 1, 9, 1, 0, 0));
    bus.flush = 0;
    issue(0, 0, 13, 32'h3, 32'h4, 0, 0, 4'h8, 0, 1);
    cyc("flush", mk(32'h1, 32'h2, 4'h4, 0, 12, 0, 0, 0));
    // MUL enters hold, then reset lands mid-hold
    idle();
    cyc("mul_c1", mk(32'h3, 32'h4, 4'h8, 1, 13, 1, 0, 1));
    cyc("mul_c2", mk(32'h3, 32'h4, 4'h8, 1, 13, 1, 0, 1));
    resetn = 0;
    issue(15, 16, 14, 32'hF, 32'hF0, 0, 0, 4'h2, 0, 1);
    cyc("reset_mid_hold", zero_e);
    resetn = 1;
    cyc("post_reset", zero_e);
    idle();
    cyc("capture_after_reset", mk(32'hF, 32'hF0, 4'h2, 1, 14, 1, 0, 0));
    cyc("idle_after", zero_e);
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
